masked_sbox_stage2_pini: RTL and testbench

- Second half of the 2-cycle first-order masked AES S-box. Consumes the two-share GF(2^4) inverse nibble produced by the stage-1 compression block, together with the two-share high/low input nibbles forwarded alongside it.
- Performs two PINI domain-oriented masked GF(2^4) multiplications to produce the two-share 8-bit tower-field inverse.
- Sits before the output linear map. Adds valid/ready flow control so the S-box pipeline can stall.

---
 rtl/masked_sbox_stage2_pini.sv | 135 +++++++++++++
 tb/tb_masked_sbox_stage2_pini.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_stage2_pini.sv
// Second stage of the 2-cycle first-order masked AES S-box: two domain-oriented
// masked GF(2^4) multiplications (N x ah, N x (ah^al)) with valid/ready flow control.
module masked_sbox_stage2_pini #(
  parameter int unsigned RAND_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        n0,
  input  logic [3:0]        n1,
  input  logic [7:0]        a0,
  input  logic [7:0]        a1,
  input  logic [RAND_W-1:0] ran,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        q0,
  output logic [7:0]        q1
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  if (RAND_W != 8) begin : g_bad_rand_w
    $error("masked_sbox_stage2_pini: RAND_W must be 8");
  end

  // GF(2^4) multiply, reduction polynomial x^4 + x + 1
  function automatic logic [NIB_W-1:0] gf16_mul(input logic [NIB_W-1:0] x,
                                                input logic [NIB_W-1:0] y);
    logic [NIB_W-1:0] acc;
    logic [NIB_W-1:0] t;
    acc = '0;
    t   = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) acc = acc ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  logic              v1;
  logic              v2;
  logic              en;
  logic              accept;

  logic [NIB_W-1:0]  ah0, al0, ah1, al1;
  logic [NIB_W-1:0]  s0, s1;
  logic [NIB_W-1:0]  rh, rl;

  logic [NIB_W-1:0]  p00h_d, p11h_d, c01h_d, c10h_d;
  logic [NIB_W-1:0]  p00l_d, p11l_d, c01l_d, c10l_d;

  logic [NIB_W-1:0]  p00h_q, p11h_q, c01h_q, c10h_q;
  logic [NIB_W-1:0]  p00l_q, p11l_q, c01l_q, c10l_q;

  logic [BYTE_W-1:0] q0_q, q1_q;

  assign en       = !v2 || out_ready;
  assign accept   = in_valid && en;
  assign in_ready = en;

  assign ah0 = a0[7:4];
  assign al0 = a0[3:0];
  assign ah1 = a1[7:4];
  assign al1 = a1[3:0];
  assign rh  = ran[7:4];
  assign rl  = ran[3:0];

  // Low-multiplier operand formed inside each share domain before any product
  assign s0 = ah0 ^ al0;
  assign s1 = ah1 ^ al1;

  // Inner-domain products plus cross-domain products refreshed with fresh randomness
  always_comb begin
    p00h_d = gf16_mul(n0, ah0);
    p11h_d = gf16_mul(n1, ah1);
    c01h_d = gf16_mul(n0, ah1) ^ rh;
    c10h_d = gf16_mul(n1, ah0) ^ rh;
    p00l_d = gf16_mul(n0, s0);
    p11l_d = gf16_mul(n1, s1);
    c01l_d = gf16_mul(n0, s1) ^ rl;
    c10l_d = gf16_mul(n1, s0) ^ rl;
  end

  // Valid bits shift on every enabled edge so bubbles propagate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (en) begin
      v1 <= accept;
      v2 <= v1;
    end
  end

  // S1 captures only on accept so idle-cycle randomness never enters the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p00h_q <= '0;
      p11h_q <= '0;
      c01h_q <= '0;
      c10h_q <= '0;
      p00l_q <= '0;
      p11l_q <= '0;
      c01l_q <= '0;
      c10l_q <= '0;
    end else if (accept) begin
      p00h_q <= p00h_d;
      p11h_q <= p11h_d;
      c01h_q <= c01h_d;
      c10h_q <= c10h_d;
      p00l_q <= p00l_d;
      p11l_q <= p11l_d;
      c01l_q <= c01l_d;
      c10l_q <= c10l_d;
    end
  end

  // S2 compresses within each share domain; only real results overwrite outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0_q <= '0;
      q1_q <= '0;
    end else if (en && v1) begin
      q0_q <= {p00h_q ^ c01h_q, p00l_q ^ c01l_q};
      q1_q <= {p11h_q ^ c10h_q, p11l_q ^ c10l_q};
    end
  end

  assign out_valid = v2;
  assign q0        = q0_q;
  assign q1        = q1_q;

endmodule

// File: tb/tb_masked_sbox_stage2_pini.sv
// Randomized self-checking bench for masked_sbox_stage2_pini; results are checked
// against a log/antilog GF(2^4) model with an in-order expected-result queue.
module tb_masked_sbox_stage2_pini;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] n0, n1;
  logic [7:0] a0, a1;
  logic [7:0] ran;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q0, q1;

  int n_cmp;
  int n_err;
  int out_cnt;
  logic [7:0] exp_q[$];

  logic [3:0] exp_t[15];
  int         log_t[16];

  masked_sbox_stage2_pini #(.RAND_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n0        (n0),
    .n1        (n1),
    .a0        (a0),
    .a1        (a1),
    .ran       (ran),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q0        (q0),
    .q1        (q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Powers of the primitive element x give the antilog table; log is its inverse
  task automatic build_tables();
    logic [4:0] e;
    e = 5'h1;
    for (int i = 0; i < 15; i++) begin
      exp_t[i] = e[3:0];
      log_t[e[3:0]] = i;
      e = {e[3:0], 1'b0};
      if (e[4]) e = e ^ 5'h13;
    end
  endtask

  function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    if (x == 4'h0 || y == 4'h0) return 4'h0;
    return exp_t[(log_t[x] + log_t[y]) % 15];
  endfunction

  function automatic logic [7:0] ref_q(input logic [3:0] n, input logic [7:0] a);
    return {ref_mul(n, a[7:4]), ref_mul(n, a[7:4] ^ a[3:0])};
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else check("q_unmasked", 32'(q0 ^ q1), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(ref_q(n0 ^ n1, a0 ^ a1));
    end
  end

  task automatic drive(input logic v, input logic [3:0] dn0, input logic [3:0] dn1,
                       input logic [7:0] da0, input logic [7:0] da1, input logic [7:0] dr);
    in_valid = v;
    n0 = dn0;
    n1 = dn1;
    a0 = da0;
    a1 = da1;
    ran = dr;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] snap0, snap1;
  logic [7:0] fix_a0, fix_a1;
  logic [3:0] fix_n0, fix_n1;

  initial begin
    n_cmp = 0;
    n_err = 0;
    out_cnt = 0;
    build_tables();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00);
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q0", 32'(q0), 32'd0);
    check("rst_q1", 32'(q1), 32'd0);
    rst = 1'b0;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Unmasked directed vector
    step();
    drive(1'b1, 4'h8, 4'h0, 8'h21, 8'h00, 8'h00);
    step();
    in_valid = 1'b0;
    check("unm_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check("unm_valid", 32'(out_valid), 32'd1);
    check("unm_q0", 32'(q0), 32'h3B);
    check("unm_q1", 32'(q1), 32'h00);

    // Masked directed vector with the same secrets
    step();
    drive(1'b1, 4'hD, 4'h5, 8'hE6, 8'hC7, 8'hA6);
    step();
    in_valid = 1'b0;
    step();
    check("msk_valid", 32'(out_valid), 32'd1);
    check("msk_xor", 32'(q0 ^ q1), 32'h3B);
    check("msk_q0_hidden", 32'(q0 != 8'h3B), 32'd1);
    step();

    // Streaming: 16 back-to-back operand sets
    out_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive_rand(1'b1);
      step();
      if (i >= 2) check("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("stream_count", 32'(out_cnt), 32'd16);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure with both stages full
    out_cnt = 0;
    out_ready = 1'b0;
    drive_rand(1'b1);
    step();
    drive_rand(1'b1);
    step();
    in_valid = 1'b0;
    check("bp_full_valid", 32'(out_valid), 32'd1);
    snap0 = q0;
    snap1 = q1;
    for (int i = 0; i < 5; i++) begin
      ran = 8'($urandom);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_q0_hold", 32'(q0), 32'(snap0));
      check("bp_q1_hold", 32'(q1), 32'(snap1));
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    check("bp_count", 32'(out_cnt), 32'd2);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Randomness sweep over all ran values with fixed shares
    out_cnt = 0;
    fix_n0 = 4'($urandom);
    fix_n1 = 4'($urandom);
    fix_a0 = 8'($urandom);
    fix_a1 = 8'($urandom);
    for (int r = 0; r < 256; r++) begin
      drive(1'b1, fix_n0, fix_n1, fix_a0, fix_a1, 8'(r));
      step();
      if (r >= 2) check("sweep_const", 32'(q0 ^ q1),
                        32'(ref_q(fix_n0 ^ fix_n1, fix_a0 ^ fix_a1)));
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("sweep_count", 32'(out_cnt), 32'd256);

    // ran and operands toggling without accept must not disturb outputs
    snap0 = q0;
    snap1 = q1;
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b0);
      step();
      check("idle_q0", 32'(q0), 32'(snap0));
      check("idle_q1", 32'(q1), 32'(snap1));
    end

    // Mixed random valid/ready traffic
    out_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check("mixed_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a stalled, full pipeline
    out_ready = 1'b0;
    drive_rand(1'b1);
    step();
    drive_rand(1'b1);
    step();
    in_valid = 1'b0;
    check("mid_full_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_q0", 32'(q0), 32'd0);
    check("mid_rst_q1", 32'(q1), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_no_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    check("mid_no_valid2", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
